// File: rtl/exec_ctrl_if.sv
// Execute-stage bus between the decode stage and exec_ctrl_stage.
//   master : decode side, drives the instruction, pc and operand values,
//            consumes reg2loc, branch resolution, ALU result and writeback.
//   slave  : exec_ctrl_stage side.
// Signals:
//   instr_valid  current instruction is live
//   instruction  32-bit instruction word
//   pc           address of the current instruction
//   data1        value of Rn
//   data2        value of Rm or Rt (selected by decode through reg2loc)
//   reg2loc      second read-port select (0 = instr[20:16], 1 = instr[4:0])
//   pc_src       take branch_addr as next pc
//   branch_addr  branch target (pc + 4 for non-branches)
//   alu_result   combinational ALU output
//   wb_en        registered register-file write strobe
//   wb_reg       registered destination register
//   wb_data      registered write data
interface exec_ctrl_if;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [63:0] pc;
   logic [63:0] data1;
   logic [63:0] data2;
   logic        reg2loc;
   logic        pc_src;
   logic [63:0] branch_addr;
   logic [63:0] alu_result;
   logic        wb_en;
   logic [4:0]  wb_reg;
   logic [63:0] wb_data;

   modport master (
      output instr_valid, instruction, pc, data1, data2,
      input  reg2loc, pc_src, branch_addr, alu_result, wb_en, wb_reg, wb_data
   );

   modport slave (
      input  instr_valid, instruction, pc, data1, data2,
      output reg2loc, pc_src, branch_addr, alu_result, wb_en, wb_reg, wb_data
   );
endinterface

// File: rtl/exec_ctrl_stage.sv
// Execute / memory / writeback slice of the single-issue LEGv8-subset CPU.
// Decodes instruction[31:21], runs the 64-bit ALU, accesses a private
// doubleword data memory, resolves branches and returns a one-cycle
// registered register-file write request to the decode stage.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (writeback registers and memory)
//   bus    exec_ctrl_if.slave, see the interface file for the signal list
module exec_ctrl_stage #(
   parameter int DMEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   exec_ctrl_if.slave  bus
);

   localparam int IDX_W = $clog2(DMEM_WORDS);

   typedef enum logic [2:0] {
      ALU_ZERO,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_ORR
   } alu_op_t;

   typedef enum logic [1:0] {
      SRC_B_REG,
      SRC_B_IMM12,
      SRC_B_DT9
   } src_b_t;

   // Immediate extraction helpers.
   function automatic logic signed [63:0] imm12_zx(input logic [31:0] ins);
      return {52'd0, ins[21:10]};
   endfunction

   function automatic logic signed [63:0] dt9_sx(input logic [31:0] ins);
      return {{55{ins[20]}}, ins[20:12]};
   endfunction

   function automatic logic signed [63:0] br26_off(input logic [31:0] ins);
      return {{36{ins[25]}}, ins[25:0], 2'b00};
   endfunction

   function automatic logic signed [63:0] cb19_off(input logic [31:0] ins);
      return {{43{ins[23]}}, ins[23:5], 2'b00};
   endfunction

   logic [10:0]        opcode;
   alu_op_t            alu_op;
   src_b_t             src_b;
   logic               reg2loc;
   logic               reg_write;
   logic               mem_read;
   logic               mem_to_reg;
   logic               mem_write;
   logic               is_b;
   logic               is_cbz;
   logic               is_cbnz;

   logic signed [63:0] alu_a;
   logic signed [63:0] alu_b;
   logic signed [63:0] alu_y;
   logic signed [63:0] br_off;
   logic               take;

   logic [IDX_W-1:0]   mem_idx;
   logic [63:0]        mem_rdata;
   logic [63:0]        mem [DMEM_WORDS];

   logic [4:0]         rd;
   logic               wb_en_p1;
   logic [4:0]         wb_reg_p1;
   logic signed [63:0] wb_data_p1;

   assign opcode = bus.instruction[31:21];
   assign rd     = bus.instruction[4:0];

   // Control decode; any unrecognised opcode leaves every control at 0 (NOP).
   always_comb begin
      alu_op     = ALU_ZERO;
      src_b      = SRC_B_REG;
      reg2loc    = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      mem_write  = 1'b0;
      is_b       = 1'b0;
      is_cbz     = 1'b0;
      is_cbnz    = 1'b0;
      casez (opcode)
         11'b10001011000: begin alu_op = ALU_ADD; reg_write = 1'b1; end
         11'b11001011000: begin alu_op = ALU_SUB; reg_write = 1'b1; end
         11'b10001010000: begin alu_op = ALU_AND; reg_write = 1'b1; end
         11'b10101010000: begin alu_op = ALU_ORR; reg_write = 1'b1; end
         11'b1001000100?: begin
            alu_op    = ALU_ADD;
            src_b     = SRC_B_IMM12;
            reg_write = 1'b1;
         end
         11'b1101000100?: begin
            alu_op    = ALU_SUB;
            src_b     = SRC_B_IMM12;
            reg_write = 1'b1;
         end
         11'b11111000010: begin
            alu_op     = ALU_ADD;
            src_b      = SRC_B_DT9;
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         11'b11111000000: begin
            alu_op    = ALU_ADD;
            src_b     = SRC_B_DT9;
            reg2loc   = 1'b1;
            mem_write = 1'b1;
         end
         11'b000101?????: is_b = 1'b1;
         11'b10110100???: begin is_cbz  = 1'b1; reg2loc = 1'b1; end
         11'b10110101???: begin is_cbnz = 1'b1; reg2loc = 1'b1; end
         default: ;
      endcase
   end

   // ALU: plain modulo-2^64 arithmetic, no flags are produced.
   assign alu_a = bus.data1;

   always_comb begin
      alu_b = bus.data2;
      case (src_b)
         SRC_B_IMM12: alu_b = imm12_zx(bus.instruction);
         SRC_B_DT9:   alu_b = dt9_sx(bus.instruction);
         default:     alu_b = bus.data2;
      endcase
   end

   always_comb begin
      alu_y = '0;
      case (alu_op)
         ALU_ADD: alu_y = alu_a + alu_b;
         ALU_SUB: alu_y = alu_a - alu_b;
         ALU_AND: alu_y = alu_a & alu_b;
         ALU_ORR: alu_y = alu_a | alu_b;
         default: alu_y = '0;
      endcase
   end

   // Branch resolution; non-branches report the fall-through pc + 4.
   always_comb begin
      br_off = 64'sd4;
      if (is_b)
         br_off = br26_off(bus.instruction);
      else if (is_cbz || is_cbnz)
         br_off = cb19_off(bus.instruction);
   end

   assign take = is_b
               | (is_cbz  & (bus.data2 == 64'd0))
               | (is_cbnz & (bus.data2 != 64'd0));

   assign bus.pc_src      = bus.instr_valid & take;
   assign bus.branch_addr = bus.pc + br_off;
   assign bus.alu_result  = alu_y;
   assign bus.reg2loc     = reg2loc;

   // Data memory: address bits [2:0] and those above the index alias.
   // Reads are combinational so a load sees a store from the previous cycle.
   assign mem_idx   = alu_y[IDX_W+2:3];
   assign mem_rdata = mem[mem_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DMEM_WORDS; i++)
            mem[i] <= '0;
      end else if (bus.instr_valid && mem_write) begin
         mem[mem_idx] <= bus.data2;
      end
   end

   // ---- stage boundary: writeback request registered (p1) ----
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_en_p1   <= 1'b0;
         wb_reg_p1  <= '0;
         wb_data_p1 <= '0;
      end else begin
         wb_en_p1   <= bus.instr_valid & reg_write & (rd != 5'd31);
         wb_reg_p1  <= rd;
         wb_data_p1 <= (mem_to_reg & mem_read) ? mem_rdata : alu_y;
      end
   end

   assign bus.wb_en   = wb_en_p1;
   assign bus.wb_reg  = wb_reg_p1;
   assign bus.wb_data = wb_data_p1;

endmodule

// File: tb/tb_exec_ctrl_stage.sv
module tb_exec_ctrl_stage;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   exec_ctrl_if bus ();

   exec_ctrl_stage #(.DMEM_WORDS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p,
                        input logic [63:0] d1, input logic [63:0] d2);
      bus.instr_valid = v;
      bus.instruction = ins;
      bus.pc          = p;
      bus.data1       = d1;
      bus.data2       = d2;
      #1;
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADD    = 32'h8B020023; // ADD X3,X1,X2
   localparam logic [31:0] I_SUBI   = 32'hD1000424; // SUBI X4,X1,#1
   localparam logic [31:0] I_ORR    = 32'hAA020026; // ORR X6,X1,X2
   localparam logic [31:0] I_AND    = 32'h8A020027; // AND X7,X1,X2
   localparam logic [31:0] I_STUR8  = 32'hF8008022; // STUR X2,[X1,#8]
   localparam logic [31:0] I_LDUR8  = 32'hF8408025; // LDUR X5,[X1,#8]
   localparam logic [31:0] I_STUR16 = 32'hF8010022; // STUR X2,[X1,#16]
   localparam logic [31:0] I_LDUR16 = 32'hF8410025; // LDUR X5,[X1,#16]
   localparam logic [31:0] I_LDUR0  = 32'hF8400025; // LDUR X5,[X1,#0]
   localparam logic [31:0] I_B      = 32'h17FFFFFE; // B -2
   localparam logic [31:0] I_CBZ    = 32'hB4000082; // CBZ X2,+4
   localparam logic [31:0] I_CBNZ   = 32'hB5000082; // CBNZ X2,+4
   localparam logic [31:0] I_ADD31  = 32'h8B02003F; // ADD X31,X1,X2

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      drive(1'b0, 32'h0, 64'h0, 64'h0, 64'h0);
      tick();
      tick();
      chk("rst_wb_en", {63'd0, bus.wb_en}, 64'd0);
      chk("rst_wb_reg", {59'd0, bus.wb_reg}, 64'd0);
      chk("rst_wb_data", bus.wb_data, 64'd0);
      reset = 1'b0;

      // ADD X3,X1,X2
      drive(1'b1, I_ADD, 64'h40, 64'd5, 64'd7);
      chk("add_alu", bus.alu_result, 64'd12);
      chk("add_reg2loc", {63'd0, bus.reg2loc}, 64'd0);
      chk("add_pc_src", {63'd0, bus.pc_src}, 64'd0);
      chk("add_br_addr", bus.branch_addr, 64'h44);
      tick();
      chk("add_wb_en", {63'd0, bus.wb_en}, 64'd1);
      chk("add_wb_reg", {59'd0, bus.wb_reg}, 64'd3);
      chk("add_wb_data", bus.wb_data, 64'd12);
      drive(1'b0, I_ADD, 64'h44, 64'd5, 64'd7);
      tick();
      chk("add_wb_en_drop", {63'd0, bus.wb_en}, 64'd0);

      // SUBI wraps below zero
      drive(1'b1, I_SUBI, 64'h48, 64'd0, 64'd0);
      tick();
      chk("subi_wb_reg", {59'd0, bus.wb_reg}, 64'd4);
      chk("subi_wb_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFF);

      drive(1'b1, I_ORR, 64'h4C, 64'hF0, 64'h0F);
      chk("orr_alu", bus.alu_result, 64'hFF);
      tick();
      chk("orr_wb_data", bus.wb_data, 64'hFF);
      drive(1'b1, I_AND, 64'h50, 64'hF0, 64'h0F);
      tick();
      chk("and_wb_en", {63'd0, bus.wb_en}, 64'd1);
      chk("and_wb_data", bus.wb_data, 64'h0);

      // Store then load the same doubleword
      drive(1'b1, I_STUR8, 64'h54, 64'd0, 64'hDEAD);
      chk("stur_reg2loc", {63'd0, bus.reg2loc}, 64'd1);
      chk("stur_alu", bus.alu_result, 64'd8);
      tick();
      chk("stur_wb_en", {63'd0, bus.wb_en}, 64'd0);
      drive(1'b1, I_LDUR8, 64'h58, 64'd0, 64'd0);
      tick();
      chk("ldur_wb_en", {63'd0, bus.wb_en}, 64'd1);
      chk("ldur_wb_reg", {59'd0, bus.wb_reg}, 64'd5);
      chk("ldur_wb_data", bus.wb_data, 64'hDEAD);

      // Invalid store must not land
      drive(1'b0, I_STUR16, 64'h5C, 64'd0, 64'hBEEF);
      tick();
      drive(1'b1, I_LDUR16, 64'h60, 64'd0, 64'd0);
      tick();
      chk("inv_store_load", bus.wb_data, 64'd0);

      // Branches
      drive(1'b1, I_B, 64'h100, 64'd0, 64'd0);
      chk("b_pc_src", {63'd0, bus.pc_src}, 64'd1);
      chk("b_addr", bus.branch_addr, 64'hF8);
      chk("b_alu", bus.alu_result, 64'd0);
      drive(1'b0, I_B, 64'h100, 64'd0, 64'd0);
      chk("b_invalid", {63'd0, bus.pc_src}, 64'd0);
      drive(1'b1, I_CBZ, 64'h200, 64'd0, 64'd0);
      chk("cbz_taken", {63'd0, bus.pc_src}, 64'd1);
      chk("cbz_addr", bus.branch_addr, 64'h210);
      chk("cbz_reg2loc", {63'd0, bus.reg2loc}, 64'd1);
      drive(1'b1, I_CBZ, 64'h200, 64'd0, 64'd1);
      chk("cbz_not", {63'd0, bus.pc_src}, 64'd0);
      drive(1'b1, I_CBNZ, 64'h200, 64'd0, 64'd0);
      chk("cbnz_not", {63'd0, bus.pc_src}, 64'd0);
      drive(1'b1, I_CBNZ, 64'h200, 64'd0, 64'd1);
      chk("cbnz_taken", {63'd0, bus.pc_src}, 64'd1);
      chk("cbnz_addr", bus.branch_addr, 64'h210);
      tick();
      chk("cbnz_no_wb", {63'd0, bus.wb_en}, 64'd0);

      // Write to XZR suppressed
      drive(1'b1, I_ADD31, 64'h204, 64'd1, 64'd2);
      tick();
      chk("xzr_wb_en", {63'd0, bus.wb_en}, 64'd0);

      // Unknown opcode acts as NOP
      drive(1'b1, 32'h0000_0000, 64'h208, 64'd3, 64'h1234);
      chk("nop_pc_src", {63'd0, bus.pc_src}, 64'd0);
      chk("nop_alu", bus.alu_result, 64'd0);
      chk("nop_reg2loc", {63'd0, bus.reg2loc}, 64'd0);
      tick();
      chk("nop_wb_en", {63'd0, bus.wb_en}, 64'd0);
      drive(1'b1, I_LDUR0, 64'h20C, 64'd0, 64'd0);
      tick();
      chk("nop_no_store", bus.wb_data, 64'd0);

      // Reset clears memory
      drive(1'b1, I_STUR8, 64'h300, 64'd0, 64'h55);
      tick();
      drive(1'b1, I_LDUR8, 64'h304, 64'd0, 64'd0);
      tick();
      chk("pre_rst_load", bus.wb_data, 64'h55);
      reset = 1'b1;
      drive(1'b0, 32'h0, 64'h308, 64'd0, 64'd0);
      tick();
      reset = 1'b0;
      drive(1'b1, I_LDUR8, 64'h30C, 64'd0, 64'd0);
      tick();
      chk("post_rst_load", bus.wb_data, 64'd0);

      // Store during reset is discarded; writeback held off
      reset = 1'b1;
      drive(1'b1, I_STUR16, 64'h310, 64'd0, 64'h99);
      tick();
      chk("rst_store_wb_en", {63'd0, bus.wb_en}, 64'd0);
      drive(1'b1, I_ADD, 64'h314, 64'd5, 64'd7);
      tick();
      chk("rst_add_wb_en", {63'd0, bus.wb_en}, 64'd0);
      reset = 1'b0;
      drive(1'b1, I_LDUR16, 64'h318, 64'd0, 64'd0);
      tick();
      chk("rst_store_load", bus.wb_data, 64'd0);
      chk("rst_store_ld_en", {63'd0, bus.wb_en}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
